memory_arbiter: RTL and testbench

//  Sits downstream of request_unit and shares one single-ported RAM between instruction fetch and data access.

---
 rtl/memory_arbiter.sv | 144 ++++++++++++++
 tb/tb_memory_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Shares one single-ported RAM between fetch and data; data wins unless the
// last grant was data and a fetch waits. Optional abort via MEM_ARB_TIMEOUT_EN.
module memory_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemRen,
  input  logic [ADDR_W-1:0] imemaddr,
  input  logic              dmmRen,
  input  logic              dmmWen,
  input  logic [ADDR_W-1:0] dmmaddr,
  input  logic [DATA_W-1:0] dmmstore,
  output logic              i_ready,
  output logic              d_ready,
  output logic [DATA_W-1:0] imemload,
  output logic [DATA_W-1:0] dmmload,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_busy,
  output logic              arb_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state;
  logic       last_was_d;
  logic       gnt_d;
  logic       d_req;
  logic       gnt_data;
  logic       gnt_inst;
  logic       abort;

  assign d_req    = dmmRen | dmmWen;
  assign gnt_data = d_req & ~(imemRen & last_was_d);
  assign gnt_inst = ~gnt_data & imemRen;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] busy_cnt;

  assign abort = (state == BUSY) & ram_busy &
                 (busy_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Counter is held clear in IDLE so every BUSY phase starts from zero.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      busy_cnt <= '0;
    end else if (state != BUSY) begin
      busy_cnt <= '0;
    end else begin
      busy_cnt <= busy_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      arb_err <= 1'b0;
    end else if (abort) begin
      arb_err <= 1'b1;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;

  assign abort   = 1'b0;
  assign arb_err = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      last_was_d <= 1'b0;
      gnt_d      <= 1'b0;
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
      imemload   <= '0;
      dmmload    <= '0;
      ram_ren    <= 1'b0;
      ram_wen    <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_data | gnt_inst) begin
            ram_addr   <= gnt_data ? dmmaddr : imemaddr;
            ram_wdata  <= dmmstore;
            // Read+write together resolves to a write.
            ram_wen    <= gnt_data & dmmWen;
            ram_ren    <= gnt_inst | (gnt_data & ~dmmWen);
            gnt_d      <= gnt_data;
            last_was_d <= gnt_data;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (abort) begin
            ram_ren <= 1'b0;
            ram_wen <= 1'b0;
            if (gnt_d) begin
              d_ready <= 1'b1;
              dmmload <= '0;
            end else begin
              i_ready  <= 1'b1;
              imemload <= '0;
            end
            state <= RESP;
          end else if (!ram_busy) begin
            ram_ren <= 1'b0;
            ram_wen <= 1'b0;
            if (gnt_d) begin
              d_ready <= 1'b1;
              if (ram_ren) begin
                dmmload <= ram_rdata;
              end
            end else begin
              i_ready  <= 1'b1;
              imemload <= ram_rdata;
            end
            state <= RESP;
          end
        end
        RESP: begin
          i_ready <= 1'b0;
          d_ready <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized bench for memory_arbiter against a transaction-level model
// of grant order, latency, strobes and returned data.
module tb_memory_arbiter;

  logic        CLK;
  logic        nRST;
  logic        imemRen;
  logic [31:0] imemaddr;
  logic        dmmRen;
  logic        dmmWen;
  logic [31:0] dmmaddr;
  logic [31:0] dmmstore;
  logic        i_ready;
  logic        d_ready;
  logic [31:0] imemload;
  logic [31:0] dmmload;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_busy;
  logic        arb_err;

  int errs;
  int checks;

  // Model state: who was served last, and the last data-load value
  bit          last_d;
  logic [31:0] exp_dl;

  memory_arbiter dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .imemRen   (imemRen),
    .imemaddr  (imemaddr),
    .dmmRen    (dmmRen),
    .dmmWen    (dmmWen),
    .dmmaddr   (dmmaddr),
    .dmmstore  (dmmstore),
    .i_ready   (i_ready),
    .d_ready   (d_ready),
    .imemload  (imemload),
    .dmmload   (dmmload),
    .ram_ren   (ram_ren),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .ram_busy  (ram_busy),
    .arb_err   (arb_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic outs_zero(input string pfx);
    check({pfx, "_ren"}, 32'(ram_ren), 0);
    check({pfx, "_wen"}, 32'(ram_wen), 0);
    check({pfx, "_addr"}, ram_addr, 0);
    check({pfx, "_wdata"}, ram_wdata, 0);
    check({pfx, "_irdy"}, 32'(i_ready), 0);
    check({pfx, "_drdy"}, 32'(d_ready), 0);
    check({pfx, "_iload"}, imemload, 0);
    check({pfx, "_dload"}, dmmload, 0);
    check({pfx, "_err"}, 32'(arb_err), 0);
  endtask

  // One access: set requests in IDLE, follow it to the ready pulse.
  task automatic xact(
    input bit          ir,
    input bit          dr,
    input bit          dw,
    input logic [31:0] ia,
    input logic [31:0] da,
    input logic [31:0] st,
    input logic [31:0] rd,
    input int          waits
  );
    bit          gd;
    bit          gi;
    bit          wr;
    logic [31:0] ea;
    @(negedge CLK);
    check("idle_irdy", 32'(i_ready), 0);
    check("idle_drdy", 32'(d_ready), 0);
    imemRen  = ir;
    dmmRen   = dr;
    dmmWen   = dw;
    imemaddr = ia;
    dmmaddr  = da;
    dmmstore = st;
    ram_busy = 1'b0;
    gd = (dr || dw) && !(ir && last_d);
    gi = !gd && ir;
    wr = gd && dw;
    if (!gd && !gi) begin
      @(negedge CLK);
      check("nogrant_ren", 32'(ram_ren), 0);
      check("nogrant_wen", 32'(ram_wen), 0);
      check("nogrant_irdy", 32'(i_ready), 0);
      check("nogrant_drdy", 32'(d_ready), 0);
      return;
    end
    last_d = gd;
    ea = gd ? da : ia;
    for (int c = 0; c <= waits; c++) begin
      @(negedge CLK);
      check("busy_ren", 32'(ram_ren), 32'(gi || (gd && !dw)));
      check("busy_wen", 32'(ram_wen), 32'(wr));
      check("busy_addr", ram_addr, ea);
      if (wr) check("busy_wdata", ram_wdata, st);
      check("busy_irdy", 32'(i_ready), 0);
      check("busy_drdy", 32'(d_ready), 0);
      // Scramble requester inputs: they must be ignored now.
      imemRen   = 1'($urandom);
      dmmRen    = 1'($urandom);
      dmmWen    = 1'($urandom);
      imemaddr  = $urandom;
      dmmaddr   = $urandom;
      dmmstore  = $urandom;
      ram_busy  = (c < waits);
      ram_rdata = (c == waits) ? rd : $urandom;
    end
    @(negedge CLK);
    ram_busy = 1'b0;
    check("resp_irdy", 32'(i_ready), 32'(gi));
    check("resp_drdy", 32'(d_ready), 32'(gd));
    check("resp_ren", 32'(ram_ren), 0);
    check("resp_wen", 32'(ram_wen), 0);
    check("resp_err", 32'(arb_err), 0);
    if (gi) check("resp_iload", imemload, rd);
    if (gd && !dw) exp_dl = rd;
    if (gd) check("resp_dload", dmmload, exp_dl);
    imemRen = 1'b0;
    dmmRen  = 1'b0;
    dmmWen  = 1'b0;
  endtask

  initial begin
    errs      = 0;
    checks    = 0;
    last_d    = 1'b0;
    exp_dl    = '0;
    nRST      = 1'b0;
    imemRen   = 1'b0;
    imemaddr  = '0;
    dmmRen    = 1'b0;
    dmmWen    = 1'b0;
    dmmaddr   = '0;
    dmmstore  = '0;
    ram_rdata = '0;
    ram_busy  = 1'b0;
    repeat (2) @(negedge CLK);
    outs_zero("reset");
    nRST = 1'b1;

    // Plain fetch, zero wait states
    xact(1, 0, 0, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 0);
    // Fetch and data together: data first, then the fetch
    xact(1, 1, 0, 32'h104, 32'h200, 32'h0, 32'hCAFE0001, 0);
    xact(1, 1, 0, 32'h104, 32'h200, 32'h0, 32'hCAFE0002, 0);
    // Write with three wait states; dmmload keeps its value
    xact(0, 0, 1, 32'h0, 32'h40, 32'h12345678, 32'h55AA55AA, 3);
    // Read+write together behaves as a write
    xact(0, 1, 1, 32'h0, 32'h44, 32'h87654321, 32'h11111111, 1);
    // Requests held: grants alternate
    for (int k = 0; k < 4; k++) begin
      xact(1, 1, 0, 32'h108, 32'h300, 32'h0, $urandom, k % 2);
    end

    // Reset in the middle of a BUSY phase
    @(negedge CLK);
    imemRen  = 1'b1;
    imemaddr = 32'h300;
    ram_busy = 1'b1;
    @(negedge CLK);
    check("rst_pre_ren", 32'(ram_ren), 1);
    imemRen = 1'b0;
    #2 nRST = 1'b0;
    #1 outs_zero("midrst");
    @(negedge CLK);
    ram_busy = 1'b0;
    nRST     = 1'b1;
    last_d   = 1'b0;
    exp_dl   = '0;
    xact(1, 0, 0, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 0);

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      xact(($urandom % 4) != 0,
           ($urandom % 3) == 0,
           ($urandom % 4) == 0,
           32'h1000 + ($urandom % 256) * 4,
           32'h2000 + ($urandom % 256) * 4,
           $urandom, $urandom,
           int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
